// File: rtl/prbs_word_checker.sv
// PRBS7 (x^7 + x^6 + 1) checker for 64-bit recovered data words.
// It self-seeds from the received stream and tracks lock through HUNT/VERIFY/LOCKED.
module prbs_word_checker #(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_THR = 8,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      data,
    input  logic             data_vld,
    input  logic             chk_en,
    input  logic             clr_cnt,
    output logic [63:0]      data_gen,
    output logic             error_flag,
    output logic [6:0]       err_bits,
    output logic [CNT_W-1:0] err_cnt,
    output logic             lock,
    output logic [1:0]       state
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [7:0] LOCK_CNT_L = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_CNT_L = 8'(LOSS_CNT);

    logic [1:0]       state_reg, state_next;
    logic [6:0]       prbs_reg, prbs_next;
    logic [7:0]       match_cnt_reg, match_cnt_next;
    logic [7:0]       bad_cnt_reg, bad_cnt_next;
    logic [63:0]      data_gen_reg, data_gen_next;
    logic             error_flag_reg, error_flag_next;
    logic [6:0]       err_bits_reg, err_bits_next;
    logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;

    logic [70:0]      chain;
    logic [63:0]      exp_word;
    logic [63:0]      mismatch;
    logic [6:0]       pc;
    logic [CNT_W:0]   sum_wide;
    logic             accumulate;

    // Bits 0..6 of the chain are the generator history; every later bit is
    // the recurrence x[n] = x[n-7] ^ x[n-6] applied to the chain itself.
    always_comb begin
        chain      = '0;
        chain[6:0] = prbs_reg;
        for (int k = 7; k < 71; k++) begin
            chain[k] = chain[k-7] ^ chain[k-6];
        end
    end

    assign exp_word = chain[70:7];

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_mismatch
            assign mismatch[gi] = data[gi] ^ exp_word[gi];
        end
    endgenerate

    always_comb begin
        pc = '0;
        for (int k = 0; k < 64; k++) begin
            pc = pc + 7'(mismatch[k]);
        end
    end

    assign sum_wide = {1'b0, err_cnt_reg} + {{(CNT_W-6){1'b0}}, pc};

    always_comb begin
        state_next      = state_reg;
        prbs_next       = prbs_reg;
        match_cnt_next  = match_cnt_reg;
        bad_cnt_next    = bad_cnt_reg;
        data_gen_next   = data_gen_reg;
        error_flag_next = 1'b0;
        err_bits_next   = '0;
        accumulate      = 1'b0;

        if (!chk_en) begin
            state_next     = ST_HUNT;
            match_cnt_next = '0;
            bad_cnt_next   = '0;
        end else if (data_vld) begin
            case (state_reg)
                ST_HUNT: begin
                    // An all-zero seed would lock the generator at zero forever.
                    if (data[63:57] != 7'd0) begin
                        prbs_next      = data[63:57];
                        state_next     = ST_VERIFY;
                        match_cnt_next = '0;
                    end
                end
                ST_VERIFY: begin
                    data_gen_next   = exp_word;
                    error_flag_next = (pc != 7'd0);
                    err_bits_next   = pc;
                    prbs_next       = exp_word[63:57];
                    if (pc == 7'd0) begin
                        match_cnt_next = match_cnt_reg + 8'd1;
                        if (match_cnt_next == LOCK_CNT_L) begin
                            state_next   = ST_LOCKED;
                            bad_cnt_next = '0;
                        end
                    end else begin
                        state_next = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    data_gen_next   = exp_word;
                    error_flag_next = (pc != 7'd0);
                    err_bits_next   = pc;
                    prbs_next       = exp_word[63:57];
                    accumulate      = 1'b1;
                    if (int'({25'd0, pc}) >= LOSS_THR) begin
                        bad_cnt_next = bad_cnt_reg + 8'd1;
                    end else begin
                        bad_cnt_next = '0;
                    end
                    if (bad_cnt_next == LOSS_CNT_L) begin
                        state_next   = ST_HUNT;
                        bad_cnt_next = '0;
                    end
                end
                default: begin
                    state_next = ST_HUNT;
                end
            endcase
        end

        // A clear beats a coincident accumulation: that word's errors are dropped.
        err_cnt_next = err_cnt_reg;
        if (clr_cnt) begin
            err_cnt_next = '0;
        end else if (accumulate) begin
            err_cnt_next = sum_wide[CNT_W] ? {CNT_W{1'b1}} : sum_wide[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_HUNT;
            prbs_reg       <= 7'h7F;
            match_cnt_reg  <= '0;
            bad_cnt_reg    <= '0;
            data_gen_reg   <= '0;
            error_flag_reg <= 1'b0;
            err_bits_reg   <= '0;
            err_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            prbs_reg       <= prbs_next;
            match_cnt_reg  <= match_cnt_next;
            bad_cnt_reg    <= bad_cnt_next;
            data_gen_reg   <= data_gen_next;
            error_flag_reg <= error_flag_next;
            err_bits_reg   <= err_bits_next;
            err_cnt_reg    <= err_cnt_next;
        end
    end

    assign data_gen   = data_gen_reg;
    assign error_flag = error_flag_reg;
    assign err_bits   = err_bits_reg;
    assign err_cnt    = err_cnt_reg;
    assign state      = state_reg;
    assign lock       = (state_reg == ST_LOCKED);

endmodule

// File: tb/tb_prbs_word_checker.sv
// Directed bench for prbs_word_checker: two instances (default and CNT_W=8/LOSS_THR=65)
// share one stimulus stream and are scored each cycle against a reference model.
module tb_prbs_word_checker;

    logic        clk;
    logic        rst;
    logic [63:0] data;
    logic        data_vld;
    logic        chk_en;
    logic        clr_cnt;

    logic [63:0] data_gen_a, data_gen_b;
    logic        error_flag_a, error_flag_b;
    logic [6:0]  err_bits_a, err_bits_b;
    logic [31:0] err_cnt_a;
    logic [7:0]  err_cnt_b;
    logic        lock_a, lock_b;
    logic [1:0]  state_a, state_b;

    prbs_word_checker #(.LOCK_CNT(16), .LOSS_THR(8), .LOSS_CNT(4), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .data(data), .data_vld(data_vld), .chk_en(chk_en),
        .clr_cnt(clr_cnt), .data_gen(data_gen_a), .error_flag(error_flag_a),
        .err_bits(err_bits_a), .err_cnt(err_cnt_a), .lock(lock_a), .state(state_a)
    );

    prbs_word_checker #(.LOCK_CNT(16), .LOSS_THR(65), .LOSS_CNT(4), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .data(data), .data_vld(data_vld), .chk_en(chk_en),
        .clr_cnt(clr_cnt), .data_gen(data_gen_b), .error_flag(error_flag_b),
        .err_bits(err_bits_b), .err_cnt(err_cnt_b), .lock(lock_b), .state(state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      st;
        logic [6:0]      s;
        int              mcnt;
        int              bcnt;
        longint unsigned ecnt;
        logic [63:0]     dgen;
        logic            eflag;
        int              ebits;
    } mdl_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    mdl_t m_a, m_b;
    mdl_t q_a[$];
    mdl_t q_b[$];
    logic [6:0] tx_s;

    // 64 pattern bits following a 7-bit history s (s[6] most recent).
    function automatic logic [63:0] prbs_word(input logic [6:0] s);
        logic [70:0] b;
        b      = '0;
        b[6:0] = s;
        for (int k = 7; k < 71; k++) b[k] = b[k-7] ^ b[k-6];
        return b[70:7];
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input logic r, input logic v, input logic en,
                                   input logic c, input logic [63:0] d, input int lock_cnt,
                                   input int loss_thr, input int loss_cnt,
                                   input longint unsigned cmax);
        mdl_t        n;
        logic [63:0] e;
        int          pcnt;
        n       = m;
        n.eflag = 1'b0;
        n.ebits = 0;
        if (r) begin
            n.st = 2'd0; n.s = 7'h7F; n.mcnt = 0; n.bcnt = 0; n.ecnt = 0; n.dgen = '0;
            return n;
        end
        if (c) n.ecnt = 0;
        if (!en) begin
            n.st = 2'd0; n.mcnt = 0; n.bcnt = 0;
            return n;
        end
        if (!v) return n;
        if (m.st == 2'd0) begin
            if (d[63:57] != 7'd0) begin
                n.s = d[63:57]; n.st = 2'd1; n.mcnt = 0;
            end
            return n;
        end
        e       = prbs_word(m.s);
        pcnt    = $countones(d ^ e);
        n.dgen  = e;
        n.eflag = (pcnt != 0);
        n.ebits = pcnt;
        n.s     = e[63:57];
        if (m.st == 2'd1) begin
            if (pcnt == 0) begin
                n.mcnt = m.mcnt + 1;
                if (n.mcnt == lock_cnt) begin n.st = 2'd2; n.bcnt = 0; end
            end else begin
                n.st = 2'd0;
            end
        end else begin
            if (!c) n.ecnt = (m.ecnt + pcnt > cmax) ? cmax : m.ecnt + pcnt;
            n.bcnt = (pcnt >= loss_thr) ? m.bcnt + 1 : 0;
            if (n.bcnt == loss_cnt) begin n.st = 2'd0; n.bcnt = 0; end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction: drive, push model expectations, clock, pop and compare both DUTs.
    task automatic step(input logic r, input logic v, input logic en, input logic c,
                        input logic [63:0] mask);
        mdl_t        e_a, e_b;
        logic [63:0] w;
        rst      = r;
        data_vld = v;
        chk_en   = en;
        clr_cnt  = c;
        if (v) begin
            w    = prbs_word(tx_s);
            tx_s = w[63:57];
            data = w ^ mask;
        end else begin
            data = {$urandom, $urandom};
        end
        m_a = mstep(m_a, r, v, en, c, data, 16, 8, 4, 64'hFFFF_FFFF);
        m_b = mstep(m_b, r, v, en, c, data, 16, 65, 4, 64'd255);
        q_a.push_back(m_a);
        q_b.push_back(m_b);
        @(posedge clk);
        #1;
        cyc++;
        e_a = q_a.pop_front();
        e_b = q_b.pop_front();
        chk("a_state", 64'(state_a), 64'(e_a.st));
        chk("a_lock", 64'(lock_a), 64'(e_a.st == 2'd2));
        chk("a_data_gen", data_gen_a, e_a.dgen);
        chk("a_error_flag", 64'(error_flag_a), 64'(e_a.eflag));
        chk("a_err_bits", 64'(err_bits_a), 64'(e_a.ebits));
        chk("a_err_cnt", 64'(err_cnt_a), e_a.ecnt);
        chk("b_state", 64'(state_b), 64'(e_b.st));
        chk("b_lock", 64'(lock_b), 64'(e_b.st == 2'd2));
        chk("b_data_gen", data_gen_b, e_b.dgen);
        chk("b_error_flag", 64'(error_flag_b), 64'(e_b.eflag));
        chk("b_err_bits", 64'(err_bits_b), 64'(e_b.ebits));
        chk("b_err_cnt", 64'(err_cnt_b), e_b.ecnt);
        $display("cyc=%0d rst=%0b vld=%0b en=%0b clr=%0b | a: st=%0d lock=%0b ef=%0b eb=%0d cnt=%0d | b: st=%0d lock=%0b cnt=%0d",
                 cyc, r, v, en, c, state_a, lock_a, error_flag_a, err_bits_a, err_cnt_a,
                 state_b, lock_b, err_cnt_b);
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
    endtask

    initial begin
        longint unsigned saved_cnt;
        rst = 1'b1; data = '0; data_vld = 1'b0; chk_en = 1'b0; clr_cnt = 1'b0;
        tx_s = 7'h01;
        m_a = '{st: 2'd0, s: 7'h7F, mcnt: 0, bcnt: 0, ecnt: 0, dgen: '0, eflag: 1'b0, ebits: 0};
        m_b = m_a;

        // Reset values
        step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        chk("reset_state", 64'(state_a), 64'd0);
        chk("reset_err_cnt", 64'(err_cnt_a), 64'd0);

        // Clean lock: seed + 16 clean words
        clean(16);
        chk("lock_not_yet", 64'(lock_a), 64'd0);
        clean(1);
        chk("lock_after_17", 64'(lock_a), 64'd1);
        chk("lock_b_after_17", 64'(lock_b), 64'd1);
        clean(2);

        // Single-bit error then three 3-bit errors
        step(1'b0, 1'b1, 1'b1, 1'b0, 64'h20);
        chk("bit5_err_bits", 64'(err_bits_a), 64'd1);
        chk("bit5_err_cnt", 64'(err_cnt_a), 64'd1);
        clean(1);
        chk("flag_one_pulse", 64'(error_flag_a), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 64'h8000_0001_0000_0100);
        chk("three_bit_err_cnt", 64'(err_cnt_a), 64'd10);
        chk("three_bit_lock", 64'(lock_a), 64'd1);

        // Loss of lock: four all-zero words
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF & prbs_word(tx_s));
        chk("loss_held_3", 64'(lock_a), 64'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, prbs_word(tx_s));
        chk("loss_after_4", 64'(lock_a), 64'd0);
        chk("loss_b_stays", 64'(lock_b), 64'd1);
        clean(17);
        chk("relock_17", 64'(lock_a), 64'd1);

        // Zero data keeps HUNT; seed then corrupted word returns to HUNT
        step(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b0, prbs_word(tx_s));
        chk("zero_seed_hunt", 64'(state_a), 64'd0);
        saved_cnt = m_a.ecnt;
        clean(1);
        chk("seed_verify", 64'(state_a), 64'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 64'h1);
        chk("verify_fail_hunt", 64'(state_a), 64'd0);
        chk("verify_fail_cnt", 64'(err_cnt_a), saved_cnt);

        // Gapped valid words still lock after 17 valid words
        for (int i = 0; i < 34; i++) step(1'b0, (i % 2) == 0, 1'b1, 1'b0, 64'd0);
        chk("gapped_lock", 64'(lock_a), 64'd1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 64'h200);
        chk("clr_wins_a", 64'(err_cnt_a), 64'd0);
        chk("clr_wins_b", 64'(err_cnt_b), 64'd0);

        // chk_en low forces HUNT, then relock
        step(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
        chk("chk_en_hunt", 64'(state_b), 64'd0);
        clean(17);
        chk("relock_b", 64'(lock_b), 64'd1);

        // Saturation: four fully inverted words
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sat_b_255", 64'(err_cnt_b), 64'd255);
        chk("sum_a_256", 64'(err_cnt_a), 64'd256);
        chk("sat_b_lock", 64'(lock_b), 64'd1);
        chk("inv_a_unlock", 64'(lock_a), 64'd0);

        // Reset mid-stream
        clean(2);
        step(1'b1, 1'b1, 1'b1, 1'b0, 64'd0);
        chk("rst_lock", 64'(lock_b), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt_b), 64'd0);
        chk("rst_data_gen", data_gen_b, 64'd0);
        clean(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
